// File: rtl/dfr_mem_arbiter_pkg.sv
// rtl/dfr_mem_arbiter_pkg.sv - shared types and ctrl/address field positions for the DFR memory arbiter
package dfr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  // Host address split: upper byte is the page taken from ctrl, lower byte the local offset
  localparam int HOST_PAGE_MSB   = 15;
  localparam int HOST_PAGE_LSB   = 8;
  localparam int HOST_OFFSET_MSB = 7;
  localparam int HOST_OFFSET_LSB = 0;

  // Bit positions inside the config block's ctrl register
  localparam int CTRL_START    = 0;
  localparam int CTRL_BUSY     = 1;
  localparam int CTRL_SEL_MSB  = 7;
  localparam int CTRL_SEL_LSB  = 4;
  localparam int CTRL_PAGE_MSB = 15;
  localparam int CTRL_PAGE_LSB = 8;

  localparam logic [15:0] DENIED_MAX = 16'hFFFF;

endpackage

// File: rtl/dfr_mem_arbiter_if.sv
// rtl/dfr_mem_arbiter_if.sv - host and DFR-core access ports of the memory arbiter
interface dfr_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int SEL_WIDTH  = 4
) ();

  logic                  start;
  logic [SEL_WIDTH-1:0]  host_sel;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic                  host_wen;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic [DATA_WIDTH-1:0] host_rdata;
  logic                  busy;

  logic                  core_start;
  logic                  core_done;
  logic [SEL_WIDTH-1:0]  core_sel;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic                  core_wen;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic [DATA_WIDTH-1:0] core_rdata;

  // Requesting side: config regs plus DFR core
  modport master (
    output start, host_sel, host_addr, host_wen, host_wdata,
    output core_done, core_sel, core_addr, core_wen, core_wdata,
    input  host_rdata, busy, core_start, core_rdata
  );

  // Arbiter side
  modport slave (
    input  start, host_sel, host_addr, host_wen, host_wdata,
    input  core_done, core_sel, core_addr, core_wen, core_wdata,
    output host_rdata, busy, core_start, core_rdata
  );

endinterface

// File: rtl/dfr_mem_arbiter_rd_sel_pipe.sv
// rtl/dfr_mem_arbiter_rd_sel_pipe.sv - read-tag delay line matching the bank read latency
module dfr_rd_sel_pipe #(
  parameter int TAG_WIDTH = 6,
  parameter int DEPTH     = 1
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 Local_Reset,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic [TAG_WIDTH-1:0] tag_out
);

  logic [TAG_WIDTH-1:0] stage [DEPTH];

  // Shift the tag of every access cycle so it meets its bank data at the output
  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/dfr_mem_arbiter.sv
// rtl/dfr_mem_arbiter.sv - bank ownership FSM, address/write mux and read steering between host and DFR core
module dfr_mem_arbiter
  import dfr_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_BANKS  = 4,
  parameter int SEL_WIDTH  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            Local_Reset,
  dfr_mem_arbiter_if.slave                bus,
  output logic [ADDR_WIDTH-1:0]           bank_addr,
  output logic [DATA_WIDTH-1:0]           bank_wdata,
  output logic [NUM_BANKS-1:0]            bank_wen,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rdata,
  output logic [15:0]                     denied_cnt
);

  localparam int                 TAG_WIDTH = SEL_WIDTH + 2;
  localparam logic [SEL_WIDTH:0] SEL_LIMIT = (SEL_WIDTH + 1)'(NUM_BANKS);
  localparam logic [2:0]         DRAIN_LEN = 3'(RD_LATENCY);

  arb_state_t            state;
  logic                  start_q;
  logic                  busy_q;
  logic                  core_start_q;
  logic [2:0]            drain_cnt;
  logic [15:0]           denied_q;

  logic                  start_edge;
  logic                  owner_is_core;
  logic [SEL_WIDTH-1:0]  owner_sel;
  logic                  owner_wen;
  logic                  sel_in_range;
  logic [TAG_WIDTH-1:0]  tag_in;
  logic [TAG_WIDTH-1:0]  tag_out;
  logic                  tag_core;
  logic [SEL_WIDTH-1:0]  tag_sel;
  logic                  tag_valid;
  logic [DATA_WIDTH-1:0] rd_word;

  assign start_edge    = bus.start & ~start_q;
  assign owner_is_core = (state != IDLE);

  // Ownership FSM: a start edge in IDLE arms one core run; DRAIN lets in-flight core reads land
  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
      drain_cnt    <= '0;
    end else begin
      start_q <= bus.start;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state        <= ARM;
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ARM: begin
          state        <= RUN;
          core_start_q <= 1'b0;
        end
        RUN: begin
          if (bus.core_done) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LEN;
          end
        end
        DRAIN: begin
          if (drain_cnt == 3'd1) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        default: begin
          state        <= IDLE;
          busy_q       <= 1'b0;
          core_start_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.core_start = core_start_q;

  // Owner mux onto the shared bank bus; write enables are gated by reset so they fall immediately
  always_comb begin
    owner_sel    = owner_is_core ? bus.core_sel   : bus.host_sel;
    owner_wen    = owner_is_core ? bus.core_wen   : bus.host_wen;
    bank_addr    = owner_is_core ? bus.core_addr  : bus.host_addr;
    bank_wdata   = owner_is_core ? bus.core_wdata : bus.host_wdata;
    sel_in_range = ({1'b0, owner_sel} < SEL_LIMIT);
    bank_wen     = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_wen[i] = owner_wen & sel_in_range & (owner_sel == SEL_WIDTH'(i)) & ~Local_Reset;
    end
  end

  // Count host writes dropped because the core owns the banks, saturating at all-ones
  always_ff @(posedge S_AXI_ACLK or posedge Local_Reset) begin
    if (Local_Reset) begin
      denied_q <= '0;
    end else if (bus.host_wen && owner_is_core && (denied_q != DENIED_MAX)) begin
      denied_q <= denied_q + 16'd1;
    end
  end

  assign denied_cnt = denied_q;

  assign tag_in = {owner_is_core, owner_sel, sel_in_range};

  dfr_rd_sel_pipe #(
    .TAG_WIDTH (TAG_WIDTH),
    .DEPTH     (RD_LATENCY)
  ) u_rd_sel_pipe (
    .S_AXI_ACLK  (S_AXI_ACLK),
    .Local_Reset (Local_Reset),
    .tag_in      (tag_in),
    .tag_out     (tag_out)
  );

  assign tag_core  = tag_out[TAG_WIDTH-1];
  assign tag_sel   = tag_out[SEL_WIDTH:1];
  assign tag_valid = tag_out[0];

  // Pick the returning bank word and hand it only to the requester that issued the read
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (tag_valid && (tag_sel == SEL_WIDTH'(i))) rd_word = bank_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
    bus.host_rdata = tag_core ? '0 : rd_word;
    bus.core_rdata = tag_core ? rd_word : '0;
  end

endmodule

// File: tb/tb_dfr_mem_arbiter.sv
// tb/tb_dfr_mem_arbiter.sv - randomized self-checking bench for dfr_mem_arbiter with bank and shadow-memory models
module tb_dfr_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int NB = 4;
  localparam int SW = 4;
  localparam int RD_LAT = 2;

  logic                 clk;
  logic                 rst;
  logic [AW-1:0]        bank_addr;
  logic [DW-1:0]        bank_wdata;
  logic [NB-1:0]        bank_wen;
  logic [NB*DW-1:0]     bank_rdata;
  logic [15:0]          denied_cnt;

  int checks;
  int passed;
  int exp_denied;

  dfr_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW)) bus ();

  dfr_mem_arbiter #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_BANKS (NB), .SEL_WIDTH (SW), .RD_LATENCY (RD_LAT)
  ) dut (
    .S_AXI_ACLK  (clk),
    .Local_Reset (rst),
    .bus         (bus),
    .bank_addr   (bank_addr),
    .bank_wdata  (bank_wdata),
    .bank_wen    (bank_wen),
    .bank_rdata  (bank_rdata),
    .denied_cnt  (denied_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: single-port memories with RD_LAT cycles of read latency
  logic [DW-1:0] bank_mem [int];
  logic [DW-1:0] rd_pipe [NB][RD_LAT];

  function automatic int mkey(input int sel, input logic [AW-1:0] addr);
    return sel * 65536 + int'(addr);
  endfunction

  function automatic logic [DW-1:0] bank_read(input int b, input logic [AW-1:0] addr);
    int k;
    k = mkey(b, addr);
    return bank_mem.exists(k) ? bank_mem[k] : '0;
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      for (int s = RD_LAT - 1; s > 0; s--) rd_pipe[b][s] <= rd_pipe[b][s-1];
      rd_pipe[b][0] <= bank_read(b, bank_addr);
      if (bank_wen[b]) bank_mem[mkey(b, bank_addr)] = bank_wdata;
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_rd
    assign bank_rdata[g*DW +: DW] = rd_pipe[g][RD_LAT-1];
  end

  // Reference model: what every in-range accepted write should leave behind
  logic [DW-1:0] shadow [int];
  int            wr_keys [$];

  function automatic logic [DW-1:0] shadow_rd(input int k);
    return shadow.exists(k) ? shadow[k] : '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.host_sel = '0; bus.host_addr = '0; bus.host_wen = 1'b0; bus.host_wdata = '0;
    bus.core_done = 1'b0; bus.core_sel = '0; bus.core_addr = '0; bus.core_wen = 1'b0; bus.core_wdata = '0;
  endtask

  task automatic begin_run();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;
  endtask

  task automatic end_run();
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    repeat (RD_LAT + 2) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    clear_inputs();
    repeat (2) tick();
    #1;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", bus.busy); else passed++;
    checks++; if (bus.core_start !== 1'b0) $display("FAIL reset_core_start got %b expected 0", bus.core_start); else passed++;
    checks++; if (bank_wen !== '0) $display("FAIL reset_bank_wen got %b expected 0", bank_wen); else passed++;
    checks++; if (denied_cnt !== 16'd0) $display("FAIL reset_denied got %h expected 0", denied_cnt); else passed++;
    checks++; if (bus.host_rdata !== '0) $display("FAIL reset_host_rdata got %h expected 0", bus.host_rdata); else passed++;
    checks++; if (bus.core_rdata !== '0) $display("FAIL reset_core_rdata got %h expected 0", bus.core_rdata); else passed++;
    @(negedge clk);
    rst = 1'b0;
    exp_denied = 0;
    tick();
  endtask

  task automatic test_host_write();
    int sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bus.host_sel = 4'd2; bus.host_addr = 16'h0105; bus.host_wdata = 32'hDEADBEEF; bus.host_wen = 1'b1;
    #1;
    checks++; if (bank_wen !== 4'b0100) $display("FAIL host_wr_wen got %b expected 0100", bank_wen); else passed++;
    checks++; if (bank_addr !== 16'h0105) $display("FAIL host_wr_addr got %h expected 0105", bank_addr); else passed++;
    checks++; if (bank_wdata !== 32'hDEADBEEF) $display("FAIL host_wr_data got %h expected deadbeef", bank_wdata); else passed++;
    tick();
    shadow[mkey(2, 16'h0105)] = 32'hDEADBEEF;
    wr_keys.push_back(mkey(2, 16'h0105));
    bus.host_wen = 1'b0;
    #1;
    checks++; if (bank_wen !== 4'b0000) $display("FAIL host_wr_wen_drop got %b expected 0000", bank_wen); else passed++;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      sel = $urandom_range(0, NB - 1);
      addr = AW'($urandom);
      data = $urandom;
      bus.host_sel = SW'(sel); bus.host_addr = addr; bus.host_wdata = data; bus.host_wen = 1'b1;
      #1;
      checks++; if (bank_wen !== NB'(1 << sel)) $display("FAIL host_wr_rand_wen sel=%0d got %b expected %b", sel, bank_wen, NB'(1 << sel)); else passed++;
      tick();
      shadow[mkey(sel, addr)] = data;
      wr_keys.push_back(mkey(sel, addr));
    end
    bus.host_wen = 1'b0;
    tick();
  endtask

  task automatic test_host_read();
    logic [DW-1:0] exp_q [$];
    int n_rd;
    int k;
    logic [DW-1:0] e;
    n_rd = wr_keys.size();
    for (int n = 0; n < n_rd + RD_LAT; n++) begin
      if (n >= RD_LAT) begin
        e = exp_q.pop_front();
        checks++; if (bus.host_rdata !== e) $display("FAIL host_rd[%0d] got %h expected %h", n - RD_LAT, bus.host_rdata, e); else passed++;
        checks++; if (bus.core_rdata !== '0) $display("FAIL host_rd_core_quiet got %h expected 0", bus.core_rdata); else passed++;
      end
      if (n < n_rd) begin
        k = wr_keys[n];
        bus.host_sel = SW'(k / 65536); bus.host_addr = AW'(k % 65536); bus.host_wen = 1'b0;
        exp_q.push_back(shadow_rd(k));
      end
      tick();
    end
  endtask

  task automatic test_start_run();
    int lat;
    logic saw_start, saw_busy;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bus.start = 1'b0;
    tick();
    addr = AW'($urandom); data = $urandom;
    bus.start = 1'b1;
    bus.host_sel = 4'd0; bus.host_addr = addr; bus.host_wdata = data; bus.host_wen = 1'b1;
    #1;
    checks++; if (bank_wen !== 4'b0001) $display("FAIL start_edge_host_wr got %b expected 0001", bank_wen); else passed++;
    checks++; if (bus.core_start !== 1'b0) $display("FAIL start_pre_edge got %b expected 0", bus.core_start); else passed++;
    tick();
    shadow[mkey(0, addr)] = data;
    bus.host_wen = 1'b0;
    #1;
    checks++; if (bus.core_start !== 1'b1) $display("FAIL core_start_pulse got %b expected 1", bus.core_start); else passed++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL busy_after_start got %b expected 1", bus.busy); else passed++;
    tick();
    checks++; if (bus.core_start !== 1'b0) $display("FAIL core_start_one_cycle got %b expected 0", bus.core_start); else passed++;
    checks++; if (bus.busy !== 1'b1) $display("FAIL busy_run got %b expected 1", bus.busy); else passed++;
    repeat (3) tick();
    bus.core_done = 1'b1;
    lat = 20;
    for (int k = 1; k <= 20; k++) begin
      tick();
      bus.core_done = 1'b0;
      if (bus.busy === 1'b0) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat !== RD_LAT + 1) $display("FAIL done_to_idle_latency got %0d expected %0d", lat, RD_LAT + 1); else passed++;
    saw_start = 1'b0; saw_busy = 1'b0;
    repeat (5) begin
      tick();
      saw_start |= bus.core_start;
      saw_busy  |= bus.busy;
    end
    checks++; if (saw_start !== 1'b0) $display("FAIL held_start_rerun got %b expected 0", saw_start); else passed++;
    checks++; if (saw_busy !== 1'b0) $display("FAIL held_start_busy got %b expected 0", saw_busy); else passed++;
    bus.start = 1'b0;
    bus.host_sel = 4'd0; bus.host_addr = addr;
    repeat (RD_LAT) tick();
    checks++; if (bus.host_rdata !== data) $display("FAIL start_edge_wr_readback got %h expected %h", bus.host_rdata, data); else passed++;
  endtask

  task automatic test_denied();
    begin_run();
    for (int n = 0; n < 3; n++) begin
      bus.host_sel = SW'($urandom_range(0, NB - 1)); bus.host_addr = AW'($urandom);
      bus.host_wdata = $urandom; bus.host_wen = 1'b1;
      #1;
      checks++; if (bank_wen !== '0) $display("FAIL denied_wen[%0d] got %b expected 0", n, bank_wen); else passed++;
      tick();
      exp_denied++;
    end
    bus.host_wen = 1'b0;
    #1;
    checks++; if (denied_cnt !== 16'(exp_denied)) $display("FAIL denied_count got %0d expected %0d", denied_cnt, exp_denied); else passed++;
    force dut.denied_q = 16'hFFFD;
    #1;
    release dut.denied_q;
    exp_denied = 32'hFFFD;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      bus.host_wen = 1'b1;
      tick();
      if (exp_denied < 32'hFFFF) exp_denied++;
      checks++; if (denied_cnt !== 16'(exp_denied)) $display("FAIL denied_sat[%0d] got %h expected %h", n, denied_cnt, 16'(exp_denied)); else passed++;
    end
    bus.host_wen = 1'b0;
    end_run();
  endtask

  task automatic test_core_access();
    int sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int ck [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] e;
    begin_run();
    for (int n = 0; n < 6; n++) begin
      sel = (n == 0) ? 1 : $urandom_range(0, NB - 1);
      addr = AW'($urandom); data = $urandom;
      bus.core_sel = SW'(sel); bus.core_addr = addr; bus.core_wdata = data; bus.core_wen = 1'b1;
      bus.host_sel = SW'($urandom_range(0, NB - 1)); bus.host_addr = AW'($urandom);
      #1;
      checks++; if (bank_wen !== NB'(1 << sel)) $display("FAIL core_wr_wen sel=%0d got %b expected %b", sel, bank_wen, NB'(1 << sel)); else passed++;
      checks++; if (bank_addr !== addr) $display("FAIL core_wr_addr got %h expected %h", bank_addr, addr); else passed++;
      tick();
      shadow[mkey(sel, addr)] = data;
      ck.push_back(mkey(sel, addr));
    end
    bus.core_wen = 1'b0;
    ck.push_back(ck[0]);
    for (int n = 0; n < ck.size() + RD_LAT; n++) begin
      if (n >= RD_LAT) begin
        e = exp_q.pop_front();
        checks++; if (bus.core_rdata !== e) $display("FAIL core_rd[%0d] got %h expected %h", n - RD_LAT, bus.core_rdata, e); else passed++;
        checks++; if (bus.host_rdata !== '0) $display("FAIL core_rd_host_zero got %h expected 0", bus.host_rdata); else passed++;
      end
      bus.core_done = 1'b0;
      if (n < ck.size()) begin
        bus.core_sel = SW'(ck[n] / 65536); bus.core_addr = AW'(ck[n] % 65536);
        bus.core_done = (n == ck.size() - 1);
        exp_q.push_back(shadow_rd(ck[n]));
      end
      tick();
    end
    bus.core_done = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) $display("FAIL core_run_end_busy got %b expected 0", bus.busy); else passed++;
  endtask

  task automatic test_done_with_write();
    int sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    begin_run();
    sel = $urandom_range(0, NB - 1); addr = AW'($urandom); data = $urandom;
    bus.core_sel = SW'(sel); bus.core_addr = addr; bus.core_wdata = data;
    bus.core_wen = 1'b1; bus.core_done = 1'b1;
    #1;
    checks++; if (bank_wen !== NB'(1 << sel)) $display("FAIL done_wr_wen got %b expected %b", bank_wen, NB'(1 << sel)); else passed++;
    tick();
    shadow[mkey(sel, addr)] = data;
    bus.core_wen = 1'b0; bus.core_done = 1'b0;
    repeat (RD_LAT + 2) tick();
    bus.host_sel = SW'(sel); bus.host_addr = addr;
    repeat (RD_LAT) tick();
    checks++; if (bus.host_rdata !== shadow_rd(mkey(sel, addr))) $display("FAIL done_wr_readback got %h expected %h", bus.host_rdata, shadow_rd(mkey(sel, addr))); else passed++;
  endtask

  task automatic test_out_of_range();
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    addr = AW'($urandom); data = $urandom | 32'h1;
    bus.host_sel = 4'd3; bus.host_addr = addr; bus.host_wdata = data; bus.host_wen = 1'b1;
    tick();
    shadow[mkey(3, addr)] = data;
    bus.host_sel = 4'd7; bus.host_wdata = ~data;
    #1;
    checks++; if (bank_wen !== '0) $display("FAIL oor_host_wen got %b expected 0", bank_wen); else passed++;
    tick();
    bus.host_wen = 1'b0;
    repeat (RD_LAT) tick();
    checks++; if (bus.host_rdata !== '0) $display("FAIL oor_host_rdata got %h expected 0", bus.host_rdata); else passed++;
    bus.host_sel = 4'd3;
    repeat (RD_LAT) tick();
    checks++; if (bus.host_rdata !== data) $display("FAIL oor_bank3_intact got %h expected %h", bus.host_rdata, data); else passed++;
    begin_run();
    bus.core_sel = 4'd5; bus.core_addr = addr; bus.core_wdata = ~data; bus.core_wen = 1'b1;
    #1;
    checks++; if (bank_wen !== '0) $display("FAIL oor_core_wen got %b expected 0", bank_wen); else passed++;
    tick();
    bus.core_wen = 1'b0;
    repeat (RD_LAT) tick();
    checks++; if (bus.core_rdata !== '0) $display("FAIL oor_core_rdata got %h expected 0", bus.core_rdata); else passed++;
    end_run();
  endtask

  task automatic test_reset_mid_run();
    begin_run();
    bus.core_sel = 4'd1; bus.core_addr = AW'($urandom); bus.core_wdata = $urandom; bus.core_wen = 1'b1;
    #1;
    checks++; if (bank_wen !== 4'b0010) $display("FAIL midrst_pre_wen got %b expected 0010", bank_wen); else passed++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %b expected 0", bus.busy); else passed++;
    checks++; if (bank_wen !== '0) $display("FAIL midrst_wen got %b expected 0", bank_wen); else passed++;
    checks++; if (bus.core_start !== 1'b0) $display("FAIL midrst_core_start got %b expected 0", bus.core_start); else passed++;
    bus.core_wen = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    exp_denied = 0;
    tick();
    checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_idle_busy got %b expected 0", bus.busy); else passed++;
    checks++; if (denied_cnt !== 16'(exp_denied)) $display("FAIL midrst_denied got %h expected 0", denied_cnt); else passed++;
    bus.start = 1'b1;
    tick();
    checks++; if (bus.core_start !== 1'b1) $display("FAIL midrst_restart got %b expected 1", bus.core_start); else passed++;
    tick();
    checks++; if (bus.busy !== 1'b1) $display("FAIL midrst_restart_busy got %b expected 1", bus.busy); else passed++;
    bus.start = 1'b0;
    end_run();
    checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_final_idle got %b expected 0", bus.busy); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    exp_denied = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_host_write();
    test_host_read();
    test_start_run();
    test_denied();
    test_core_access();
    test_done_with_write();
    test_out_of_range();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1);
  end

endmodule
